// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures one retirement record per cycle from the WB
// stage. Records are held in a circular buffer and presented to a
// valid/ready consumer. Full-FIFO drops, a wrapping 16-bit sequence number
// and a sticky halt/done indication let the consumer reconstruct the
// retirement stream.
module commit_trace_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_instr,
    input  logic        wb_rd_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_rd_data,
    input  logic        wb_mem_we,
    input  logic [31:0] wb_mem_addr,
    input  logic [31:0] wb_mem_data,
    input  logic        halt_in,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [15:0] trace_seq,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_instr,
    output logic        trace_rd_we,
    output logic [4:0]  trace_rd,
    output logic [31:0] trace_rd_data,
    output logic        trace_mem_we,
    output logic [31:0] trace_mem_addr,
    output logic [31:0] trace_mem_data,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        trace_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_we;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
    } rec_t;

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   seq_q, seq_d;
    logic          halted_q, halted_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_q, drop_d;

    logic   push_req, push, pop, full, empty;
    rec_t   new_rec;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Build the record to store; writes to x0 are never reported.
    always_comb begin
        new_rec          = '0;
        new_rec.seq      = seq_q;
        new_rec.pc       = wb_pc;
        new_rec.instr    = wb_instr;
        new_rec.rd_we    = wb_rd_we && (wb_rd != 5'd0);
        new_rec.rd       = wb_rd;
        new_rec.rd_data  = wb_rd_data;
        new_rec.mem_we   = wb_mem_we;
        new_rec.mem_addr = wb_mem_addr;
        new_rec.mem_data = wb_mem_data;
    end

    // Push/pop arbitration and next-state computation.
    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        push_req   = wb_valid && !halted_q;
        pop        = !empty && trace_ready;
        // A full FIFO still accepts a push when the head is popped this cycle.
        push       = push_req && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        halted_d   = halted_q || halt_in;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);

        // seq counts every retirement seen before halt, dropped or not.
        if (push_req) seq_d = seq_q + 16'd1;

        if (push_req && !push) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
    end

    // Control state registers, cleared asynchronously.
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            halted_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            halted_q   <= halted_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Record storage write port.
    // NOTE: the storage array has no reset; stale entries are never visible because trace_valid follows the count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_rec;
    end

    // Head record and status outputs, all derived from registered state.
    rec_t head;
    assign head           = mem_q[rd_ptr_q];
    assign trace_valid    = !empty;
    assign trace_seq      = head.seq;
    assign trace_pc       = head.pc;
    assign trace_instr    = head.instr;
    assign trace_rd_we    = head.rd_we;
    assign trace_rd       = head.rd;
    assign trace_rd_data  = head.rd_data;
    assign trace_mem_we   = head.mem_we;
    assign trace_mem_addr = head.mem_addr;
    assign trace_mem_data = head.mem_data;
    assign overflow       = overflow_q;
    assign drop_count     = drop_q;
    assign trace_done     = halted_q && empty;

endmodule
